// File: rtl/rtype_pkg.sv
// Shared types and constants for the R-type sequencer: FSM states, funct
// encodings, ALU selects, error codes and the HALT sentinel word.
package rtype_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/rtype_decode.sv
// Combinational R-type field decoder: splits the instruction word and maps
// funct to an ALU select, flagging legality and the HALT sentinel.
module rtype_decode
  import rtype_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [2:0]  alu_op,
  output logic        legal,
  output logic        is_halt
);

  logic [5:0] opcode;
  logic [5:0] funct;

  always_comb begin
    opcode  = instr[31:26];
    funct   = instr[5:0];
    rs      = instr[25:21];
    rt      = instr[20:16];
    rd      = instr[15:11];
    is_halt = (instr == HALT_WORD);
    legal   = 1'b0;
    alu_op  = ALU_ADD;
    if (opcode == 6'd0) begin
      legal = 1'b1;
      case (funct)
        FUNCT_ADD: alu_op = ALU_ADD;
        FUNCT_SUB: alu_op = ALU_SUB;
        FUNCT_AND: alu_op = ALU_AND;
        FUNCT_OR:  alu_op = ALU_OR;
        FUNCT_SLT: alu_op = ALU_SLT;
        FUNCT_NOR: alu_op = ALU_NOR;
        default:   legal  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle R-type sequencer: FETCH/DECODE/EXEC/WB loop from pc 0 until a
// HALT word, the retire limit or a fetch timeout. All outputs are registered.
module rtype_seq_ctrl
  import rtype_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int MAX_INSTR     = 255,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              instr_req,
  output logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic [4:0]        R_register_1,
  output logic [4:0]        R_register_2,
  output logic [4:0]        W_register,
  output logic              RegEn,
  output logic [2:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [7:0]        retired
);

  localparam logic [7:0] TO_LAST   = 8'(FETCH_TIMEOUT - 1);
  localparam logic [7:0] RET_LIMIT = 8'(MAX_INSTR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic [4:0]        rd1_q, rd1_d, rd2_q, rd2_d, wreg_q, wreg_d;
  logic [2:0]        op_q, op_d;
  logic              regen_q, regen_d, req_q, req_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        retired_q, retired_d, retired_inc;

  logic [4:0] dec_rs, dec_rt, dec_rd;
  logic [2:0] dec_op;
  logic       dec_legal, dec_halt;

  rtype_decode u_decode (
    .instr   (ir_q),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .rd      (dec_rd),
    .alu_op  (dec_op),
    .legal   (dec_legal),
    .is_halt (dec_halt)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    to_cnt_d    = to_cnt_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    wreg_d      = wreg_q;
    op_d        = op_q;
    regen_d     = 1'b0;
    err_d       = err_q;
    retired_d   = retired_q;
    retired_inc = (retired_q == 8'hFF) ? 8'hFF : retired_q + 8'd1;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d   = FETCH;
          pc_d      = '0;
          retired_d = '0;
          err_d     = ERR_NONE;
          to_cnt_d  = '0;
        end
      end
      FETCH: begin
        if (instr_valid) begin
          ir_d     = instr;
          to_cnt_d = '0;
          state_d  = DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d    = ERR_TIMEOUT;
          to_cnt_d = '0;
          state_d  = HALT;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      DECODE: begin
        // The HALT word also advances pc so pc points past the last fetched word.
        if (dec_halt) begin
          pc_d    = pc_q + 1'b1;
          state_d = HALT;
        end else if (!dec_legal) begin
          if (err_q == ERR_NONE) err_d = ERR_ILLEGAL;
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end else begin
          rd1_d   = dec_rs;
          rd2_d   = dec_rt;
          op_d    = dec_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        wreg_d  = dec_rd;
        regen_d = (dec_rd != 5'd0);
        state_d = WB;
      end
      WB: begin
        retired_d = retired_inc;
        pc_d      = pc_q + 1'b1;
        state_d   = (retired_inc == RET_LIMIT) ? HALT : FETCH;
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == FETCH);
    busy_d = (state_d != IDLE) && (state_d != HALT);
    done_d = (state_d == HALT) && (state_q != HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      to_cnt_q  <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      wreg_q    <= '0;
      op_q      <= '0;
      regen_q   <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      to_cnt_q  <= to_cnt_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      wreg_q    <= wreg_d;
      op_q      <= op_d;
      regen_q   <= regen_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign instr_req    = req_q;
  assign pc           = pc_q;
  assign R_register_1 = rd1_q;
  assign R_register_2 = rd2_q;
  assign W_register   = wreg_q;
  assign RegEn        = regen_q;
  assign alu_op       = op_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Directed bench for rtype_seq_ctrl: default instance plus a MAX_INSTR=3
// instance sharing clock, reset and the instruction bus.
module tb_rtype_seq_ctrl;

  logic        clk, rst, start_a, start_b, instr_valid;
  logic [31:0] instr;
  logic        sel;

  logic       a_req, a_regen, a_busy, a_done;
  logic [7:0] a_pc, a_retired;
  logic [4:0] a_r1, a_r2, a_w;
  logic [2:0] a_op;
  logic [1:0] a_err;
  logic       b_req, b_regen, b_busy, b_done;
  logic [7:0] b_pc, b_retired;
  logic [4:0] b_r1, b_r2, b_w;
  logic [2:0] b_op;
  logic [1:0] b_err;

  rtype_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start_a), .instr_req(a_req), .pc(a_pc),
    .instr(instr), .instr_valid(instr_valid), .R_register_1(a_r1),
    .R_register_2(a_r2), .W_register(a_w), .RegEn(a_regen), .alu_op(a_op),
    .busy(a_busy), .done(a_done), .err(a_err), .retired(a_retired)
  );

  rtype_seq_ctrl #(.MAX_INSTR(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_b), .instr_req(b_req), .pc(b_pc),
    .instr(instr), .instr_valid(instr_valid), .R_register_1(b_r1),
    .R_register_2(b_r2), .W_register(b_w), .RegEn(b_regen), .alu_op(b_op),
    .busy(b_busy), .done(b_done), .err(b_err), .retired(b_retired)
  );

  wire       m_req     = sel ? b_req     : a_req;
  wire       m_regen   = sel ? b_regen   : a_regen;
  wire       m_done    = sel ? b_done    : a_done;
  wire [7:0] m_pc      = sel ? b_pc      : a_pc;
  wire [4:0] m_r1      = sel ? b_r1      : a_r1;
  wire [4:0] m_r2      = sel ? b_r2      : a_r2;
  wire [4:0] m_w       = sel ? b_w       : a_w;
  wire [2:0] m_op      = sel ? b_op      : a_op;
  wire [1:0] m_err     = sel ? b_err     : a_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  int n_chk, n_pass, n_fail;
  int n_cyc, n_regen, n_fetch, req_cycles;
  bit saw_done, saw_pc3;
  logic [4:0] last_w, last_r1, last_r2;
  logic [2:0] last_op;
  logic [7:0] f_pc;
  logic [1:0] f_err;
  logic       f_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
  endtask

  // Pulses start, then answers each fetch one cycle after instr_req rises.
  task automatic run(input bit s, input bit withhold, input bit stop_regen, input int budget);
    bit req_seen;
    bit stop;
    sel = s;
    n_cyc = 0; n_regen = 0; n_fetch = 0; req_cycles = 0;
    saw_done = 0; saw_pc3 = 0; req_seen = 0; stop = 0;
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    while (!saw_done && !stop && n_cyc < budget) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      n_cyc++;
      if (n_cyc == 1) begin f_pc = m_pc; f_err = m_err; f_req = m_req; end
      if (m_regen) begin
        n_regen++;
        last_w = m_w; last_r1 = m_r1; last_r2 = m_r2; last_op = m_op;
        if (stop_regen) stop = 1;
      end
      if (m_done) saw_done = 1;
      if (m_req) begin
        req_cycles++;
        if (m_pc == 8'd3) saw_pc3 = 1;
      end
      if (!stop) begin
        if (m_req && !withhold) begin
          if (req_seen) begin
            instr = mem[m_pc[3:0]];
            instr_valid = 1'b1;
            n_fetch++;
          end else req_seen = 1;
        end else begin
          instr_valid = 1'b0;
          req_seen = 0;
        end
      end
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    bit req_any;
    n_chk = 0; n_pass = 0; n_fail = 0;
    sel = 0; start_a = 0; start_b = 0; instr = '0; instr_valid = 0;
    rst = 1'b1;
    #3;
    chk("rst_pc", a_pc, 8'd0);
    chk("rst_req", a_req, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_err", a_err, 2'd0);
    chk("rst_retired", a_retired, 8'd0);
    chk("rst_regen", a_regen, 1'b0);
    chk("rst_wreg", a_w, 5'd0);
    chk("rst_r1", a_r1, 5'd0);
    chk("rst_op", a_op, 3'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Test 1: ADD r3,r1,r2 then HALT
    clear_mem();
    mem[0] = 32'h0022_1820;
    run(0, 0, 0, 60);
    chk("t1_done", saw_done, 1'b1);
    chk("t1_latency", n_cyc, 9);
    chk("t1_regen_cnt", n_regen, 1);
    chk("t1_wreg", last_w, 5'd3);
    chk("t1_r1", last_r1, 5'd1);
    chk("t1_r2", last_r2, 5'd2);
    chk("t1_op", last_op, 3'd0);
    chk("t1_retired", a_retired, 8'd1);
    chk("t1_err", a_err, 2'd0);
    chk("t1_busy", a_busy, 1'b0);
    @(negedge clk);
    chk("t1_done_pulse", a_done, 1'b0);

    // Test 4: fetch timeout
    run(0, 1, 0, 60);
    chk("t4_done", saw_done, 1'b1);
    chk("t4_req_cycles", req_cycles, 15);
    chk("t4_err", a_err, 2'd2);
    chk("t4_req_drop", a_req, 1'b0);

    // Test 2 (also restart after timeout): SUB r0,r4,r5 then HALT
    clear_mem();
    mem[0] = 32'h0085_0022;
    run(0, 0, 0, 60);
    chk("t2_restart_pc", f_pc, 8'd0);
    chk("t2_restart_err", f_err, 2'd0);
    chk("t2_restart_req", f_req, 1'b1);
    chk("t2_done", saw_done, 1'b1);
    chk("t2_regen_cnt", n_regen, 0);
    chk("t2_retired", a_retired, 8'd1);
    chk("t2_op", a_op, 3'd1);
    chk("t2_r1", a_r1, 5'd4);
    chk("t2_r2", a_r2, 5'd5);
    chk("t2_err", a_err, 2'd0);

    // Test 3: illegal, OR r6,r7,r8, HALT
    clear_mem();
    mem[0] = 32'h8C00_0000;
    mem[1] = 32'h00E8_3025;
    run(0, 0, 0, 80);
    chk("t3_done", saw_done, 1'b1);
    chk("t3_err", a_err, 2'd1);
    chk("t3_retired", a_retired, 8'd1);
    chk("t3_regen_cnt", n_regen, 1);
    chk("t3_wreg", last_w, 5'd6);
    chk("t3_op", last_op, 3'd3);
    chk("t3_pc", a_pc, 8'd3);

    // Test 5: reset during WB
    clear_mem();
    mem[0] = 32'h0022_1820;
    run(0, 0, 1, 60);
    chk("t5_in_wb", a_regen, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t5_regen_async", a_regen, 1'b0);
    chk("t5_busy_async", a_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req_any = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_req) req_any = 1;
    end
    chk("t5_no_req", req_any, 1'b0);
    chk("t5_pc", a_pc, 8'd0);
    chk("t5_retired", a_retired, 8'd0);

    // Test 6: MAX_INSTR=3 with four ADDs
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 32'h0043_0820;
    run(1, 0, 0, 100);
    chk("t6_done", saw_done, 1'b1);
    chk("t6_regen_cnt", n_regen, 3);
    chk("t6_retired", b_retired, 8'd3);
    chk("t6_fetches", n_fetch, 3);
    chk("t6_no_4th_fetch", saw_pc3, 1'b0);
    chk("t6_wreg", last_w, 5'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
